// File: rtl/fsm_bit_flip_detect_pkg.sv
// rtl/fsm_bit_flip_detect_pkg.sv - shared types for the serial bit-flip detector
//
// Purpose: state encoding and width shared by the detector and anything that
//          inspects its state.
package fsm_bit_flip_detect_pkg;

  localparam int STATE_W = 2;

  // IDLE means no reference bit is held yet; LAST0/LAST1 hold the last
  // sampled bit. 2'b11 is unused and is handled like IDLE.
  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'b00,
    LAST0 = 2'b01,
    LAST1 = 2'b10
  } state_e;

endpackage

// File: rtl/fsm_bit_flip_detect.sv
// rtl/fsm_bit_flip_detect.sv - Mealy detector flagging every inversion of a serial bit
//
// Purpose: remembers the previously sampled serial bit and raises det in the
//          same cycle the live input differs from it.
// Ports:
//   ser_in  in   1  serial data bit, sampled on each rising clk edge
//   clk     in   1  system clock
//   rst     in   1  synchronous active-high reset; also gates det low
//   det     out  1  combinational flip flag (ser_in differs from stored bit)
module fsm_bit_flip_detect
  import fsm_bit_flip_detect_pkg::*;
(
  input  logic ser_in,
  input  logic clk,
  input  logic rst,
  output logic det
);

  state_e state_q;
  state_e state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Every state, including the unused encoding, simply records the bit just
  // sampled; only the output depends on which reference bit is held.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE:    state_d = ser_in ? LAST1 : LAST0;
      LAST0:   state_d = ser_in ? LAST1 : LAST0;
      LAST1:   state_d = ser_in ? LAST1 : LAST0;
      default: state_d = ser_in ? LAST1 : LAST0;
    endcase
  end

  // Reset masks the flag immediately, before the state register has been
  // cleared, so a reset asserted mid-stream never reports a flip.
  always_comb begin
    det = 1'b0;
    case (state_q)
      LAST0:   det = ser_in;
      LAST1:   det = ~ser_in;
      default: det = 1'b0;
    endcase
    if (rst) begin
      det = 1'b0;
    end
  end

endmodule

// File: tb/tb_fsm_bit_flip_detect.sv
// tb/tb_fsm_bit_flip_detect.sv - scoreboard bench for the serial bit-flip detector
module tb_fsm_bit_flip_detect;

  logic clk;
  logic rst;
  logic ser_in;
  logic det;

  typedef struct {
    logic  exp;
    string name;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests;
  int   n_failed;
  bit   stim_done;

  fsm_bit_flip_detect dut (
    .ser_in (ser_in),
    .clk    (clk),
    .rst    (rst),
    .det    (det)
  );

  // 10-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic at(input int t);
    if (t > $time) #(t - $time);
  endtask

  task automatic expect_det(input int t, input logic e, input string name);
    exp_t item;
    at(t);
    item.exp  = e;
    item.name = name;
    exp_q.push_back(item);
  endtask

  // Monitor: samples det whenever an expectation is queued. Inputs are always
  // changed at an earlier time step and never at a rising edge.
  initial begin
    exp_t item;
    forever begin
      wait (exp_q.size() != 0);
      item = exp_q.pop_front();
      n_tests++;
      if (det !== item.exp) begin
        n_failed++;
        $display("FAIL %s at t=%0t: det=%b expected %b", item.name, $time, det, item.exp);
      end
    end
  end

  initial begin
    n_tests   = 0;
    n_failed  = 0;
    stim_done = 1'b0;
    rst       = 1'b1;
    ser_in    = 1'b0;

    // Reset hold with ser_in toggling
    expect_det(2, 1'b0, "rst_hold_a");
    at(3);  ser_in = 1'b1;
    expect_det(4, 1'b0, "rst_hold_b");
    at(8);  ser_in = 1'b0;
    expect_det(9, 1'b0, "rst_hold_c");
    at(12); ser_in = 1'b1;
    expect_det(13, 1'b0, "rst_hold_d");

    // Release reset; first bit only sets the reference
    at(16); rst = 1'b0; ser_in = 1'b0;
    expect_det(18, 1'b0, "first_bit_idle");
    expect_det(27, 1'b0, "first_bit_last0");

    // Sequence: changes at 30, 70, 90, 100, 150
    at(30);  ser_in = 1'b1;
    expect_det(32, 1'b1, "seq_30_rise");
    expect_det(37, 1'b0, "seq_30_after");
    expect_det(50, 1'b0, "seq_steady_1");
    at(70);  ser_in = 1'b0;
    expect_det(72, 1'b1, "seq_70_fall");
    expect_det(77, 1'b0, "seq_70_after");
    at(90);  ser_in = 1'b1;
    expect_det(92, 1'b1, "seq_90_rise");
    expect_det(97, 1'b0, "seq_90_after");
    at(100); ser_in = 1'b0;
    expect_det(102, 1'b1, "seq_100_fall");
    expect_det(107, 1'b0, "seq_100_after");
    expect_det(130, 1'b0, "seq_steady_0");
    at(150); ser_in = 1'b1;
    expect_det(152, 1'b1, "seq_150_rise");
    expect_det(157, 1'b0, "seq_150_after");

    // Back to LAST0, then a glitch that reverts before the edge
    at(160); ser_in = 1'b0;
    expect_det(162, 1'b1, "pre_glitch_fall");
    expect_det(167, 1'b0, "pre_glitch_after");
    at(176); ser_in = 1'b1;
    expect_det(177, 1'b1, "glitch_high");
    at(178); ser_in = 1'b0;
    expect_det(179, 1'b0, "glitch_low");
    expect_det(187, 1'b0, "glitch_not_latched");
    at(190); ser_in = 1'b1;
    expect_det(192, 1'b1, "glitch_state_last0");

    // Reset and input change together while in LAST1: reset wins
    at(200); ser_in = 1'b0; rst = 1'b1;
    expect_det(202, 1'b0, "rst_with_flip");
    at(208); rst = 1'b0;
    expect_det(209, 1'b0, "post_rst_idle");
    expect_det(217, 1'b0, "post_rst_first_bit");
    at(220); ser_in = 1'b1;
    expect_det(222, 1'b1, "post_rst_flip");

    // Reset asserted while det is high drops it at once and clears history
    at(226); ser_in = 1'b0;
    expect_det(227, 1'b1, "mid_flip_high");
    at(228); rst = 1'b1;
    expect_det(229, 1'b0, "mid_rst_gate");
    at(236); rst = 1'b0; ser_in = 1'b1;
    expect_det(237, 1'b0, "history_lost");
    expect_det(247, 1'b0, "history_lost_after");
    at(250); ser_in = 1'b0;
    expect_det(252, 1'b1, "final_flip");

    stim_done = 1'b1;
  end

  initial begin
    int waited;
    wait (stim_done);
    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      #1;
      waited++;
    end
    if (exp_q.size() != 0) begin
      n_tests++;
      n_failed++;
      $display("FAIL drain: %0d checks left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: stimulus incomplete at t=%0t, expected done by 300", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
